round_scoreboard: RTL and testbench

Match-level scorekeeper for the tug-of-war game. Consumes the single-cycle round-win pulses produced by the playfield end detection, keeps per-player round counts, and drives HEX5 (left/computer) and HEX0 (right/human) with the scores. It also issues the round-restart pulse that recentres the light chain, and declares the match winner at a configurable score. Sits directly downstream of the playfield and end detector, and feeds `res` back into the light modules.

---
 rtl/game_pkg.sv | 31 +++
 rtl/seg7_digit.sv | 12 +
 rtl/round_scoreboard.sv | 141 ++++++++++++++
 tb/tb_round_scoreboard.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared tug-of-war game types: scoreboard FSM states, score type, seven-segment helpers.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        HOLD       = 2'd1,
        RESTART    = 2'd2,
        MATCH_OVER = 2'd3
    } score_state_t;

    typedef logic [2:0] score_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] seg7_of(input score_t s);
        logic [6:0] seg;
        case (s)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            default: seg = 7'b1111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// One score digit for the seven-segment display, with a blank override.
module seg7_digit
    import game_pkg::*;
(
    input  logic [2:0] i_score,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    assign o_seg = i_blank ? SEG_BLANK : seg7_of(score_t'(i_score));

endmodule

// File: rtl/round_scoreboard.sv
// Match scorekeeper for the tug-of-war game: round counts, restart pulse, match winner.
// Optional macro SCOREBOARD_BLINK_EN blinks the winner's digit while the match is over.
module round_scoreboard
    import game_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       win_left,
    input  logic       win_right,
    input  logic       new_match,
    output logic       round_res,
    output logic       match_over,
    output logic       winner,
    output logic [6:0] hex_left,
    output logic [6:0] hex_right
);

    localparam int               CNT_W     = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam score_t           WIN       = score_t'(WIN_SCORE);

    score_t           r_score_l;
    score_t           r_score_r;
    score_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_round_res;
    logic             r_match_over;
    logic             r_winner;
    logic             w_blank_l;
    logic             w_blank_r;

    function automatic score_t sat_inc(input score_t s);
        return (s >= WIN) ? WIN : s + 3'd1;
    endfunction

`ifdef SCOREBOARD_BLINK_EN
    logic r_blank;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= PLAY;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_cnt        <= '0;
            r_round_res  <= 1'b0;
            r_match_over <= 1'b0;
            r_winner     <= 1'b0;
`ifdef SCOREBOARD_BLINK_EN
            r_blank      <= 1'b0;
`endif
        end else if (new_match) begin
            r_state      <= RESTART;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_cnt        <= '0;
            r_round_res  <= 1'b1;
            r_match_over <= 1'b0;
            r_winner     <= 1'b0;
`ifdef SCOREBOARD_BLINK_EN
            r_blank      <= 1'b0;
`endif
        end else begin
            case (r_state)
                PLAY: begin
                    // A simultaneous pulse is a tie: no score change, round replayed.
                    if (win_left || win_right) begin
                        if (win_left && !win_right)
                            r_score_l <= sat_inc(r_score_l);
                        if (win_right && !win_left)
                            r_score_r <= sat_inc(r_score_r);
                        r_cnt   <= HOLD_LOAD;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_round_res <= 1'b1;
                        if (r_score_l == WIN || r_score_r == WIN) begin
                            r_state      <= MATCH_OVER;
                            r_match_over <= 1'b1;
                            r_winner     <= (r_score_r == WIN);
`ifdef SCOREBOARD_BLINK_EN
                            r_cnt        <= HOLD_LOAD;
                            r_blank      <= 1'b1;
`endif
                        end else begin
                            r_state <= RESTART;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESTART: begin
                    r_round_res <= 1'b0;
                    r_state     <= PLAY;
                end
                MATCH_OVER: begin
`ifdef SCOREBOARD_BLINK_EN
                    // Free-running blink phase: blank first, then digit, each HOLD_CYCLES long.
                    if (r_cnt == '0) begin
                        r_cnt   <= HOLD_LOAD;
                        r_blank <= ~r_blank;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
`endif
                end
                default: r_state <= PLAY;
            endcase
        end
    end

`ifdef SCOREBOARD_BLINK_EN
    assign w_blank_l = r_blank & r_match_over & ~r_winner;
    assign w_blank_r = r_blank & r_match_over &  r_winner;
`else
    assign w_blank_l = 1'b0;
    assign w_blank_r = 1'b0;
`endif

    seg7_digit u_digit_left (
        .i_score (r_score_l),
        .i_blank (w_blank_l),
        .o_seg   (hex_left)
    );

    seg7_digit u_digit_right (
        .i_score (r_score_r),
        .i_blank (w_blank_r),
        .o_seg   (hex_right)
    );

    assign round_res  = r_round_res;
    assign match_over = r_match_over;
    assign winner     = r_winner;

endmodule

// File: tb/tb_round_scoreboard.sv
// Randomised bench for round_scoreboard against an edge-timestamp reference model.
module tb_round_scoreboard;

    localparam int WS = 3;
    localparam int HC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       win_left = 1'b0;
    logic       win_right = 1'b0;
    logic       new_match = 1'b0;
    logic       round_res;
    logic       match_over;
    logic       winner;
    logic [6:0] hex_left;
    logic [6:0] hex_right;

    round_scoreboard #(.WIN_SCORE(WS), .HOLD_CYCLES(HC)) dut (
        .clk        (clk),
        .reset      (reset),
        .win_left   (win_left),
        .win_right  (win_right),
        .new_match  (new_match),
        .round_res  (round_res),
        .match_over (match_over),
        .winner     (winner),
        .hex_left   (hex_left),
        .hex_right  (hex_right)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    int n_cmp = 0;
    int n_bad = 0;
    int t = 0;

    // Reference state: scores plus edge timestamps of pending events.
    int m_sl, m_sr;
    bit m_over, m_win;
    int m_hold_end, m_rr_edge, m_accept, m_decide;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset(input int first_play_edge);
        m_sl = 0; m_sr = 0; m_over = 0; m_win = 0;
        m_hold_end = -1; m_rr_edge = -1; m_decide = -1;
        m_accept = first_play_edge;
    endtask

    task automatic model_edge(input bit wl, input bit wr, input bit nm);
        if (!reset) begin
            model_reset(t + 1);
        end else if (nm) begin
            model_reset(t + 2);
            m_rr_edge = t;
        end else if (m_hold_end == t) begin
            m_hold_end = -1;
            if (m_sl == WS || m_sr == WS) begin
                m_over = 1; m_win = (m_sr == WS); m_decide = t;
            end else begin
                m_rr_edge = t; m_accept = t + 2;
            end
        end else if (!m_over && m_hold_end < 0 && t >= m_accept && (wl || wr)) begin
            if (wl && !wr && m_sl < WS) m_sl++;
            if (wr && !wl && m_sr < WS) m_sr++;
            m_hold_end = t + HC;
        end
    endtask

    task automatic check_outputs(input int e);
        bit blank;
        logic [6:0] exp_l, exp_r;
        blank = 0;
`ifdef SCOREBOARD_BLINK_EN
        if (m_over && (((e - m_decide) / HC) % 2 == 0)) blank = 1;
`endif
        exp_l = (blank && !m_win) ? 7'h7F : seg_tab[m_sl];
        exp_r = (blank &&  m_win) ? 7'h7F : seg_tab[m_sr];
        check_val("round_res",  32'(round_res),  32'(m_over || (m_rr_edge == e)));
        check_val("match_over", 32'(match_over), 32'(m_over));
        check_val("winner",     32'(winner),     32'(m_over && m_win));
        check_val("hex_left",   32'(hex_left),   32'(exp_l));
        check_val("hex_right",  32'(hex_right),  32'(exp_r));
    endtask

    task automatic step(input bit wl, input bit wr, input bit nm);
        win_left = wl; win_right = wr; new_match = nm;
        @(posedge clk);
        model_edge(wl, wr, nm);
        @(negedge clk);
        check_outputs(t);
        win_left = 0; win_right = 0; new_match = 0;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        model_reset(0);
        #1 check_outputs(-2);
        idle(2);
        reset = 1'b1;

        // single right win, then extra pulses during HOLD
        step(0, 1, 0); idle(HC + 2);
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); idle(HC + 2);
        // tie round
        step(1, 1, 0); idle(HC + 2);
        // three left wins decide the match
        for (int i = 0; i < WS; i++) begin step(1, 0, 0); idle(HC + 2); end
        step(0, 1, 0); idle(3 * HC);
        // new match, then a counted win
        step(0, 0, 1); idle(2);
        step(1, 0, 0); idle(2);
        // asynchronous reset in the middle of HOLD
        #2 reset = 1'b0;
        model_reset(t);
        #1 check_outputs(-2);
        idle(1);
        reset = 1'b1;
        idle(2);

        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
